// File: rtl/start_supervisor.sv
// Initiator-side supervisor: issues a start pulse, times the target's done
// pulse against a latency window, and latches the first failure cause.
module start_supervisor #(
  parameter int EXP_LAT = 13,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 31,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          clear_i,
  input  logic          done_i,
  input  logic          alert_i,
  output logic          start_o,
  output logic          busy_o,
  output logic          ok_o,
  output logic          fail_o,
  output logic [2:0]    fail_code_o,
  output logic [CW-1:0] lat_o
);

  // state  | meaning
  // IDLE   | waiting for req_i
  // LAUNCH | start pulse to target, cnt primed to 1
  // WAIT   | counting cycles until done_i or timeout
  // PASS   | one-cycle ok pulse
  // FAIL   | sticky failure, cause held until clear_i
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    PASS   = 3'd3,
    FAIL   = 3'd4
  } state_t;

  localparam logic [2:0] C_ALERT    = 3'b001;
  localparam logic [2:0] C_SPURIOUS = 3'b010;
  localparam logic [2:0] C_EARLY    = 3'b011;
  localparam logic [2:0] C_TIMEOUT  = 3'b100;
  localparam logic [2:0] C_LATE     = 3'b101;
  localparam logic [2:0] C_INVALID  = 3'b111;

  localparam logic [CW-1:0] LAT_LO = CW'(EXP_LAT - TOL);
  localparam logic [CW-1:0] LAT_HI = CW'(EXP_LAT + TOL);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);

  // Plain vector so that encodings outside the enum stay representable.
  logic [2:0]    state_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt         <= '0;
      lat_o       <= '0;
      fail_code_o <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (alert_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_ALERT;
          end else if (done_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_SPURIOUS;
          end else if (req_i) begin
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt <= CW'(1);
          if (alert_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_ALERT;
          end else if (done_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_EARLY;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (alert_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_ALERT;
          end else if (done_i) begin
            lat_o <= cnt;
            if (cnt < LAT_LO) begin
              state_q     <= FAIL;
              fail_code_o <= C_EARLY;
            end else if (cnt > LAT_HI) begin
              state_q     <= FAIL;
              fail_code_o <= C_LATE;
            end else begin
              state_q <= PASS;
            end
          end else if (cnt == T_MAX) begin
            state_q     <= FAIL;
            fail_code_o <= C_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PASS: begin
          if (alert_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_ALERT;
          end else if (done_i) begin
            state_q     <= FAIL;
            fail_code_o <= C_SPURIOUS;
          end else begin
            state_q <= IDLE;
          end
        end
        FAIL: begin
          if (clear_i) begin
            state_q     <= IDLE;
            fail_code_o <= 3'b000;
          end
        end
        default: begin
          state_q     <= FAIL;
          fail_code_o <= C_INVALID;
        end
      endcase
    end
  end

  assign start_o = (state_q == LAUNCH);
  assign busy_o  = (state_q == LAUNCH) || (state_q == WAIT);
  assign ok_o    = (state_q == PASS);
  assign fail_o  = (state_q == FAIL);

endmodule
